// File: rtl/mac_result_serializer.sv
// Purpose : drains one WIDTH-bit accumulator word LSB-first onto a 1-bit serial port, optional even parity.
// Latency : bit 0 is presented the cycle after the load edge; WIDTH+PARITY+1 cycles per word minimum.
// Backpr. : ser_ready=0 holds the current bit; load_ready stays low until the frame has fully drained.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   load_valid/ready    word handshake; load_data is the word to send
//   ser_valid/ready     serial handshake; ser_data is the current bit
//   ser_last            current bit is the final bit of the frame
//   frame_done          registered pulse the cycle after the final bit is accepted
module mac_result_serializer #(
   parameter int WIDTH  = 8,
   parameter int PARITY = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             ser_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shift_reg;
   logic [CW-1:0]    bit_cnt;
   logic             par_bit;
   logic             done_set;
   logic             last_data_bit;

   assign load_ready    = (state == IDLE);
   assign last_data_bit = (bit_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         par_bit    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= done_set;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  shift_reg <= load_data;
                  bit_cnt   <= '0;
                  // Parity is taken from the whole word up front so the
                  // shift register can drain without extra bookkeeping.
                  par_bit   <= ^load_data;
               end
            end
            SHIFT: begin
               if (ser_ready) begin
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= bit_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      ser_last  = 1'b0;
      done_set  = 1'b0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_data  = shift_reg[0];
            ser_last  = last_data_bit && (PARITY == 0);
            if (ser_ready && last_data_bit) begin
               if (PARITY != 0) begin
                  state_nxt = PAR;
               end else begin
                  state_nxt = IDLE;
                  done_set  = 1'b1;
               end
            end
         end
         PAR: begin
            ser_valid = 1'b1;
            ser_data  = par_bit;
            ser_last  = 1'b1;
            if (ser_ready) begin
               state_nxt = IDLE;
               done_set  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Bench for mac_result_serializer: one instance without parity (index 0), one with parity (index 1).
// A frame-level reference model (bit list per frame, read position) checks every cycle,
// while table vectors and hand-written sequences cover the specific corner cases.
module tb_mac_result_serializer;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;

   logic       lv0 = 1'b0, sr0 = 1'b0;
   logic [7:0] ld0 = 8'h00;
   logic       lr0, sd0, sv0, sl0, fd0;

   logic       lv1 = 1'b0, sr1 = 1'b0;
   logic [7:0] ld1 = 8'h00;
   logic       lr1, sd1, sv1, sl1, fd1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mac_result_serializer #(.WIDTH(8), .PARITY(0)) dut0 (
      .clk(clk), .reset(reset),
      .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
      .ser_data(sd0), .ser_valid(sv0), .ser_ready(sr0), .ser_last(sl0),
      .frame_done(fd0)
   );

   mac_result_serializer #(.WIDTH(8), .PARITY(1)) dut1 (
      .clk(clk), .reset(reset),
      .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
      .ser_data(sd1), .ser_valid(sv1), .ser_ready(sr1), .ser_last(sl1),
      .frame_done(fd1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic v, input logic d, input logic l,
                           input logic f, input logic r, input logic ev, input logic ed,
                           input logic el, input logic ef, input logic er);
      chk({tag, "_valid"}, v, ev);
      chk({tag, "_data"},  d, ed);
      chk({tag, "_last"},  l, el);
      chk({tag, "_done"},  f, ef);
      chk({tag, "_ready"}, r, er);
   endtask

   // ---------------- reference model: each frame is a list of bits ----------------
   logic fr [2][9];
   int   pos [2];
   int   len [2];
   logic mfd [2];

   task automatic m_clear();
      for (int i = 0; i < 2; i++) begin
         pos[i] = 0;
         len[i] = 0;
         mfd[i] = 1'b0;
      end
   endtask

   task automatic m_step(input int i, input logic lv, input logic sr, input logic [7:0] d);
      logic nfd;
      int   ones;
      nfd  = 1'b0;
      ones = 0;
      if (pos[i] < len[i]) begin
         if (sr) begin
            pos[i] = pos[i] + 1;
            if (pos[i] == len[i]) nfd = 1'b1;
         end
      end else if (lv) begin
         for (int b = 0; b < 8; b++) begin
            fr[i][b] = d[b];
            ones     = ones + int'(d[b]);
         end
         fr[i][8] = (ones % 2 == 1);
         len[i]   = (i == 1) ? 9 : 8;
         pos[i]   = 0;
      end
      mfd[i] = nfd;
   endtask

   task automatic m_check(input int i, input logic v, input logic d, input logic l,
                          input logic f, input logic r);
      logic ev, ed, el;
      ev = (pos[i] < len[i]);
      ed = ev ? fr[i][pos[i]] : 1'b0;
      el = ev && (pos[i] == len[i] - 1);
      chk_outs($sformatf("model%0d", i), v, d, l, f, r, ev, ed, el, mfd[i], !ev);
   endtask

   initial m_clear();

   always @(posedge clk) begin
      if (!reset) m_clear();
      else begin
         m_step(0, lv0, sr0, ld0);
         m_step(1, lv1, sr1, ld1);
      end
   end

   always @(negedge clk) begin
      if (!reset) m_clear();
      m_check(0, sv0, sd0, sl0, fd0, lr0);
      m_check(1, sv1, sd1, sl1, fd1, lr1);
   end

   // ---------------- directed helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Both instances load the same word with ser_ready held high.
   task automatic frame_both(input logic [7:0] data, input logic exp_par, input int vi);
      lv0 = 1'b1; ld0 = data; sr0 = 1'b1;
      lv1 = 1'b1; ld1 = data; sr1 = 1'b1;
      next_cycle();
      lv0 = 1'b0; lv1 = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c < 8) begin
            chk_outs($sformatf("v%0d_p0_b%0d", vi, c), sv0, sd0, sl0, fd0, lr0,
                     1'b1, data[c], (c == 7), 1'b0, 1'b0);
            chk_outs($sformatf("v%0d_p1_b%0d", vi, c), sv1, sd1, sl1, fd1, lr1,
                     1'b1, data[c], 1'b0, 1'b0, 1'b0);
         end else if (c == 8) begin
            chk_outs($sformatf("v%0d_p0_end", vi), sv0, sd0, sl0, fd0, lr0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk_outs($sformatf("v%0d_p1_par", vi), sv1, sd1, sl1, fd1, lr1,
                     1'b1, exp_par, 1'b1, 1'b0, 1'b0);
         end else begin
            chk_outs($sformatf("v%0d_p0_idle", vi), sv0, sd0, sl0, fd0, lr0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_outs($sformatf("v%0d_p1_end", vi), sv1, sd1, sl1, fd1, lr1,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         end
         next_cycle();
      end
   endtask

   // Loads a word into the no-parity instance and records the accepted bits.
   // If ign_cyc >= 0, a stray load of 0xFF is pulsed on that cycle of the frame.
   task automatic collect0(input logic [7:0] data, input int ign_cyc, input int cycles,
                           output logic [7:0] rx, output int nb, output int nfd);
      rx = 8'h00; nb = 0; nfd = 0;
      lv0 = 1'b1; ld0 = data; sr0 = 1'b1;
      next_cycle();
      lv0 = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         if (c == ign_cyc) begin
            lv0 = 1'b1; ld0 = 8'hFF;
         end else begin
            lv0 = 1'b0;
         end
         @(negedge clk);
         if (c == ign_cyc) chk("ignored_load_ready", lr0, 1'b0);
         if (sv0 && sr0) begin
            if (nb < 8) rx[nb] = sd0;
            nb++;
         end
         if (fd0) nfd++;
         next_cycle();
      end
      lv0 = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       exp_par;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [7:0] rx;
      int nb, nfd, idx;
      logic [7:0] stall_word;

      vecs[0] = '{8'hA5, 1'b0};
      vecs[1] = '{8'h07, 1'b1};
      vecs[2] = '{8'h03, 1'b0};
      vecs[3] = '{8'h3C, 1'b0};
      vecs[4] = '{8'h5A, 1'b0};
      vecs[5] = '{8'h81, 1'b0};
      vecs[6] = '{8'hFF, 1'b0};
      vecs[7] = '{8'h01, 1'b1};
      vecs[8] = '{8'h80, 1'b1};
      vecs[9] = '{8'hFE, 1'b1};

      // Reset held with random inputs: everything stays at reset values.
      for (int c = 0; c < 6; c++) begin
         lv0 = 1'($urandom); ld0 = 8'($urandom); sr0 = 1'($urandom);
         lv1 = 1'($urandom); ld1 = 8'($urandom); sr1 = 1'($urandom);
         @(negedge clk);
         chk_outs("rst0", sv0, sd0, sl0, fd0, lr0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         chk_outs("rst1", sv1, sd1, sl1, fd1, lr1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         next_cycle();
      end
      lv0 = 1'b0; lv1 = 1'b0; sr0 = 1'b1; sr1 = 1'b1;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_outs("post_rst0", sv0, sd0, sl0, fd0, lr0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         chk_outs("post_rst1", sv1, sd1, sl1, fd1, lr1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         next_cycle();
      end

      // Table vectors: plain and parity frames side by side.
      for (int v = 0; v < 10; v++) frame_both(vecs[v].data, vecs[v].exp_par, v);

      // Stall on bit 2 of 0x3C (parity instance) for three cycles.
      stall_word = 8'h3C;
      lv1 = 1'b1; ld1 = stall_word; sr1 = 1'b1;
      next_cycle();
      lv1 = 1'b0;
      for (int c = 0; c < 13; c++) begin
         sr1 = !(c >= 2 && c < 5);
         idx = (c < 2) ? c : ((c < 5) ? 2 : c - 3);
         @(negedge clk);
         if (c < 12) begin
            chk($sformatf("stall_valid_c%0d", c), sv1, 1'b1);
            chk($sformatf("stall_data_c%0d", c), sd1, (idx < 8) ? stall_word[idx] : 1'b0);
            chk($sformatf("stall_done_c%0d", c), fd1, 1'b0);
         end else begin
            chk("stall_done_end", fd1, 1'b1);
         end
         next_cycle();
      end
      sr1 = 1'b1;

      // Stray load during a 0x5A frame is ignored.
      collect0(8'h5A, 3, 12, rx, nb, nfd);
      chk("ignored_word", rx, 8'h5A);
      chk("ignored_nbits", nb, 8);
      chk("ignored_ndone", nfd, 1);

      // Reset asserted while bit 4 of 0xF0 is presented.
      lv0 = 1'b1; ld0 = 8'hF0; sr0 = 1'b1;
      next_cycle();
      lv0 = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("abort_bit%0d", c), sd0, (c == 4) ? 1'b1 : 1'b0);
         if (c < 4) next_cycle();
      end
      #2 reset = 1'b0;
      #1;
      chk_outs("abort_now", sv0, sd0, sl0, fd0, lr0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      next_cycle();
      next_cycle();
      reset = 1'b1;
      nfd = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fd0) nfd++;
         next_cycle();
      end
      chk("abort_no_done", nfd, 0);
      collect0(8'h81, -1, 10, rx, nb, nfd);
      chk("after_abort_word", rx, 8'h81);
      chk("after_abort_nbits", nb, 8);
      chk("after_abort_ndone", nfd, 1);

      // Random traffic, backpressure and occasional resets, checked by the model.
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 249) != 0);
         lv0 = 1'($urandom); ld0 = 8'($urandom); sr0 = ($urandom_range(0, 3) != 0);
         lv1 = 1'($urandom); ld1 = 8'($urandom); sr1 = ($urandom_range(0, 3) != 0);
         next_cycle();
      end
      reset = 1'b1;
      lv0 = 1'b0; lv1 = 1'b0; sr0 = 1'b1; sr1 = 1'b1;
      for (int c = 0; c < 12; c++) next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
